// File: rtl/cdb_pkg.sv
// Shared CDB definitions: bus geometry, tag field layout and the tag comparison
// used by every consumer that snoops the common data bus.
package cdb_pkg;

  localparam int CDB_LANES     = 4;
  localparam int TAG_W         = 8;
  localparam int DATA_W        = 32;
  localparam int TAG_VALID_BIT = 7;

  // Producing-unit one-hot codes, tag bits [6:3]
  localparam logic [3:0] MEM = 4'b1000;
  localparam logic [3:0] ADD = 4'b0100;
  localparam logic [3:0] MUL = 4'b0010;
  localparam logic [3:0] DIV = 4'b0001;

  typedef struct packed {
    logic       valid;
    logic [3:0] unit;
    logic [2:0] id;
  } tag_t;

  // A lane only wakes a waiting operand when its tag is marked valid.
  function automatic logic tag_match(input logic [TAG_W-1:0] cdb_tag,
                                     input logic [TAG_W-1:0] want_tag);
    return cdb_tag[TAG_VALID_BIT] && (cdb_tag == want_tag);
  endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// Combinational round-robin picker: from a start pointer, selects up to
// NUM_LANES valid requesters in circular order and reports lane mapping.
module cdb_rr_picker #(
  parameter int NUM_REQ   = 8,
  parameter int NUM_LANES = 4,
  localparam int PTR_W    = $clog2(NUM_REQ),
  localparam int LANE_W   = $clog2(NUM_LANES)
) (
  input  logic [NUM_REQ-1:0]                i_req_valid,
  input  logic [PTR_W-1:0]                  i_rr_ptr,
  output logic [NUM_REQ-1:0]                o_grant,
  output logic [NUM_LANES-1:0][PTR_W-1:0]   o_lane_idx,
  output logic [NUM_LANES-1:0]              o_lane_vld,
  output logic [PTR_W-1:0]                  o_next_ptr
);

  always_comb begin : p_pick
    int idx;
    int cnt;
    int nxt;
    o_grant    = '0;
    o_lane_idx = '0;
    o_lane_vld = '0;
    o_next_ptr = i_rr_ptr;
    idx        = 0;
    cnt        = 0;
    nxt        = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(i_rr_ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      // k-th hit goes to lane k; the pointer follows the last hit
      if (i_req_valid[idx[PTR_W-1:0]] && (cnt < NUM_LANES)) begin
        o_grant[idx[PTR_W-1:0]]    = 1'b1;
        o_lane_idx[cnt[LANE_W-1:0]] = idx[PTR_W-1:0];
        o_lane_vld[cnt[LANE_W-1:0]] = 1'b1;
        cnt = cnt + 1;
        nxt = (idx + 1 == NUM_REQ) ? 0 : idx + 1;
        o_next_ptr = nxt[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: grants up to NUM_LANES results per cycle and
// broadcasts them registered one cycle later. Optional counters: CDB_ARB_STATS_EN.
module cdb_arbiter #(
  parameter int NUM_REQ   = 8,
  parameter int NUM_LANES = cdb_pkg::CDB_LANES,
  parameter int DATA_W    = cdb_pkg::DATA_W,
  parameter int TAG_W     = cdb_pkg::TAG_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  output logic [NUM_REQ-1:0]          req_grant,
  output logic [NUM_LANES*DATA_W-1:0] CDB_data_serialized,
  output logic [NUM_LANES*TAG_W-1:0]  CDB_tag_serialized
`ifdef CDB_ARB_STATS_EN
  ,
  output logic [31:0]                 stat_broadcasts,
  output logic [31:0]                 stat_stall_cycles
`endif
);
  import cdb_pkg::*;

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]                w_next_ptr;
  logic [PTR_W-1:0]                r_rr_ptr;
  logic [NUM_REQ-1:0]              w_valid;
  logic [NUM_REQ-1:0]              w_grant;
  logic [NUM_LANES-1:0][PTR_W-1:0] w_lane_idx;
  logic [NUM_LANES-1:0]            w_lane_vld;
  logic [DATA_W-1:0]               w_req_data [NUM_REQ];
  logic [TAG_W-1:0]                w_req_tag  [NUM_REQ];
  logic [DATA_W-1:0]               w_lane_data [NUM_LANES];
  logic [TAG_W-1:0]                w_lane_tag  [NUM_LANES];
  logic [DATA_W-1:0]               r_lane_data [NUM_LANES];
  logic [TAG_W-1:0]                r_lane_tag  [NUM_LANES];

  // Grants depend only on valid, enable, reset and pointer state
  assign w_valid   = (en && !reset) ? req_valid : '0;
  assign req_grant = w_grant;

  cdb_rr_picker #(
    .NUM_REQ   (NUM_REQ),
    .NUM_LANES (NUM_LANES)
  ) u_picker (
    .i_req_valid (w_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_lane_idx  (w_lane_idx),
    .o_lane_vld  (w_lane_vld),
    .o_next_ptr  (w_next_ptr)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign w_req_data[gi] = req_data[gi*DATA_W +: DATA_W];
      assign w_req_tag[gi]  = req_tag[gi*TAG_W +: TAG_W];
    end
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign w_lane_data[gi] = w_lane_vld[gi] ? w_req_data[w_lane_idx[gi]] : '0;
      assign w_lane_tag[gi]  = w_lane_vld[gi] ? w_req_tag[w_lane_idx[gi]]  : '0;
      assign CDB_data_serialized[(NUM_LANES-1-gi)*DATA_W +: DATA_W] = r_lane_data[gi];
      assign CDB_tag_serialized[(NUM_LANES-1-gi)*TAG_W +: TAG_W]    = r_lane_tag[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= '0;
      for (int l = 0; l < NUM_LANES; l++) begin
        r_lane_data[l] <= '0;
        r_lane_tag[l]  <= '0;
      end
    end else begin
      r_rr_ptr <= w_next_ptr;
      for (int l = 0; l < NUM_LANES; l++) begin
        r_lane_data[l] <= w_lane_data[l];
        r_lane_tag[l]  <= w_lane_tag[l];
      end
    end
  end

`ifdef CDB_ARB_STATS_EN
  logic [31:0] r_stat_bc;
  logic [31:0] r_stat_stall;
  logic [31:0] w_grant_cnt;
  logic [32:0] w_bc_sum;
  logic        w_stall;

  assign w_grant_cnt = 32'($countones(w_grant));
  assign w_bc_sum    = {1'b0, r_stat_bc} + {1'b0, w_grant_cnt};
  assign w_stall     = |(req_valid & ~w_grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stat_bc    <= '0;
      r_stat_stall <= '0;
    end else if (en) begin
      r_stat_bc <= w_bc_sum[32] ? 32'hFFFF_FFFF : w_bc_sum[31:0];
      if (w_stall && (r_stat_stall != 32'hFFFF_FFFF))
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_broadcasts   = r_stat_bc;
  assign stat_stall_cycles = r_stat_stall;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, hand-written
// reset/single/wrap sequences, then randomized traffic against a queue model.
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [7:0]   req_valid;
  logic [255:0] req_data;
  logic [63:0]  req_tag;
  logic [7:0]   req_grant;
  logic [127:0] cdb_data;
  logic [31:0]  cdb_tag;
`ifdef CDB_ARB_STATS_EN
  logic [31:0]  stat_broadcasts;
  logic [31:0]  stat_stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] dm [8];
  logic [7:0]  tm [8];

  cdb_arbiter dut (
    .clk                 (clk),
    .reset               (reset),
    .en                  (en),
    .req_valid           (req_valid),
    .req_data            (req_data),
    .req_tag             (req_tag),
    .req_grant           (req_grant),
    .CDB_data_serialized (cdb_data),
    .CDB_tag_serialized  (cdb_tag)
`ifdef CDB_ARB_STATS_EN
    ,
    .stat_broadcasts     (stat_broadcasts),
    .stat_stall_cycles   (stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit e, input logic [7:0] v);
    en        = e;
    req_valid = v;
    for (int r = 0; r < 8; r++) begin
      req_data[r*32 +: 32] = dm[r];
      req_tag[r*8 +: 8]    = tm[r];
    end
  endtask

  // One transaction: drive at negedge, check grant, then check the broadcast after posedge
  task automatic cyc(input bit e, input logic [7:0] v, input logic [7:0] eg,
                     input logic [127:0] ed, input logic [31:0] et, input string nm);
    @(negedge clk);
    drive(e, v);
    #1;
    chk({nm, ".grant"}, {120'd0, req_grant}, {120'd0, eg});
    @(posedge clk);
    #1;
    chk({nm, ".data"}, cdb_data, ed);
    chk({nm, ".tag"}, {96'd0, cdb_tag}, {96'd0, et});
  endtask

  function automatic logic [127:0] data_from_tags(input logic [31:0] et);
    logic [127:0] d;
    logic [7:0]   t;
    d = '0;
    for (int l = 0; l < 4; l++) begin
      t = et[(3-l)*8 +: 8];
      if (t != 8'h00) d[(3-l)*32 +: 32] = 32'h1000_0000 + {29'd0, t[2:0]};
    end
    return d;
  endfunction

  task automatic load_table_data();
    for (int r = 0; r < 8; r++) begin
      dm[r] = 32'h1000_0000 + r;
      tm[r] = 8'hA0 + 8'(r);
    end
  endtask

  typedef struct {
    bit          e;
    logic [7:0]  v;
    logic [7:0]  g;
    logic [31:0] t;
  } vec_t;

  vec_t tbl [12];

  int          ptr_m;
  logic [7:0]  pv;
  logic [7:0]  eg;
  logic [127:0] ed;
  logic [31:0] et;
  int          q [$];
  bit          e_r;
  int unsigned eb, es;
`ifdef CDB_ARB_STATS_EN
  logic [31:0] b0, s0;
`endif

  initial begin
    // from reset, pointer starts at 0
    tbl[0]  = '{1'b1, 8'h08, 8'h08, 32'hA300_0000};
    tbl[1]  = '{1'b1, 8'h00, 8'h00, 32'h0000_0000};
    tbl[2]  = '{1'b1, 8'hFF, 8'hF0, 32'hA4A5_A6A7};
    tbl[3]  = '{1'b1, 8'hFF, 8'h0F, 32'hA0A1_A2A3};
    tbl[4]  = '{1'b0, 8'hFF, 8'h00, 32'h0000_0000};
    tbl[5]  = '{1'b0, 8'hFF, 8'h00, 32'h0000_0000};
    tbl[6]  = '{1'b0, 8'hFF, 8'h00, 32'h0000_0000};
    tbl[7]  = '{1'b1, 8'hFF, 8'hF0, 32'hA4A5_A6A7};
    tbl[8]  = '{1'b1, 8'h0F, 8'h0F, 32'hA0A1_A2A3};
    tbl[9]  = '{1'b1, 8'h30, 8'h30, 32'hA4A5_0000};
    tbl[10] = '{1'b1, 8'hE5, 8'hC5, 32'hA6A7_A0A2};
    tbl[11] = '{1'b1, 8'h20, 8'h20, 32'hA500_0000};

    load_table_data();
    reset = 1'b1;
    drive(1'b0, 8'h00);
    #1;
    chk("reset.grant", {120'd0, req_grant}, 128'd0);
    chk("reset.data", cdb_data, 128'd0);
    chk("reset.tag", {96'd0, cdb_tag}, 128'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].e, tbl[i].v, tbl[i].g, data_from_tags(tbl[i].t), tbl[i].t, $sformatf("vec%0d", i));
      $display("vec %0d en=%0b valid=%h grant=%h tags=%h", i, tbl[i].e, tbl[i].v, req_grant, cdb_tag);
    end

    // Async reset between edges with lanes loaded; pointer is 6 here
    cyc(1'b1, 8'hFF, 8'hC3, data_from_tags(32'hA6A7_A0A1), 32'hA6A7_A0A1, "prerst");
    #2;
    reset = 1'b1;
    #1;
    chk("arst.data", cdb_data, 128'd0);
    chk("arst.tag", {96'd0, cdb_tag}, 128'd0);
    chk("arst.grant", {120'd0, req_grant}, 128'd0);
    en = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 8'hFF, 8'h0F, data_from_tags(32'hA0A1_A2A3), 32'hA0A1_A2A3, "postrst");
    $display("async reset: grant after release searched from 0, tags=%h", cdb_tag);

    // Single requester, then lanes must fall back to zero
    dm[3] = 32'h0000_002A;
    tm[3] = 8'hAB;
    cyc(1'b1, 8'h08, 8'h08, {32'h2A, 96'd0}, 32'hAB00_0000, "single");
    cyc(1'b1, 8'h00, 8'h00, 128'd0, 32'd0, "single.idle");
    $display("single requester: lane0 tag AB data 2A then idle");

    // Wrap-around: reach pointer 6 without stalls, then valid={0,2,5,6,7}
    load_table_data();
    cyc(1'b1, 8'h0F, 8'h0F, data_from_tags(32'hA0A1_A2A3), 32'hA0A1_A2A3, "wrap.pre0");
    cyc(1'b1, 8'h30, 8'h30, data_from_tags(32'hA4A5_0000), 32'hA4A5_0000, "wrap.pre1");
`ifdef CDB_ARB_STATS_EN
    b0 = stat_broadcasts;
    s0 = stat_stall_cycles;
`endif
    cyc(1'b1, 8'hE5, 8'hC5, data_from_tags(32'hA6A7_A0A2), 32'hA6A7_A0A2, "wrap.a");
    cyc(1'b1, 8'h20, 8'h20, data_from_tags(32'hA500_0000), 32'hA500_0000, "wrap.b");
`ifdef CDB_ARB_STATS_EN
    chk("stat.wrap_bc", {96'd0, stat_broadcasts - b0}, 128'd5);
    chk("stat.wrap_stall", {96'd0, stat_stall_cycles - s0}, 128'd1);
`endif
    $display("wrap-around: 6,7,0,2 then 5");

    // Randomized traffic obeying the hold-until-grant handshake
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    ptr_m = 0;
    pv    = 8'h00;
    eb    = 0;
    es    = 0;
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < 8; r++) begin
        if (!pv[r] && ($urandom_range(0, 1) == 1)) begin
          pv[r] = 1'b1;
          dm[r] = $urandom;
          tm[r] = 8'($urandom);
        end
      end
      e_r = ($urandom_range(0, 9) != 0);
      q.delete();
      if (e_r) begin
        for (int k = 0; k < 8; k++) begin
          if (pv[(ptr_m + k) % 8] && (q.size() < 4)) q.push_back((ptr_m + k) % 8);
        end
      end
      eg = '0;
      ed = '0;
      et = '0;
      for (int l = 0; l < q.size(); l++) begin
        eg[q[l]] = 1'b1;
        ed[(3-l)*32 +: 32] = dm[q[l]];
        et[(3-l)*8 +: 8]   = tm[q[l]];
      end
      cyc(e_r, pv, eg, ed, et, $sformatf("rnd%0d", n));
      if (e_r) begin
        eb += q.size();
        if ((pv & ~eg) != 8'h00) es++;
      end
      if (q.size() > 0) ptr_m = (q[q.size()-1] + 1) % 8;
      pv = pv & ~eg;
    end
`ifdef CDB_ARB_STATS_EN
    chk("stat.rnd_bc", {96'd0, stat_broadcasts}, {96'd0, eb});
    chk("stat.rnd_stall", {96'd0, stat_stall_cycles}, {96'd0, es});
`endif
    $display("random: 400 cycles, %0d broadcasts, %0d stall cycles in model", eb, es);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the 4-lane common data bus (CDB) among all completing functional-unit slots: memory, adder, multiplier and divider reservation-station entries.
- Each requester presents a result (data + 8-bit producer tag) with a valid/grant handshake.
- Each cycle the arbiter grants up to NUM_LANES requesters in round-robin order and broadcasts them on the registered, serialized CDB one cycle later.
- Replaces the free-running combinational offload so that units can stall instead of dropping results.

Parameters:
- NUM_REQ, 8: number of requesters (flattened result ports).
- NUM_LANES, 4: CDB lanes broadcast per cycle.
- DATA_W, 32: result width.
- TAG_W, 8: tag width; format {tag_valid, mem, add, mul, div, 3-bit ID}.

Ports:
- clk  in  1  clock; one clock domain; all state on posedge clk.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  global enable; when low, no grants are issued and the CDB is idle.
- req_valid  in  NUM_REQ  bit r set: requester r holds a result.
- req_data  in  NUM_REQ*DATA_W  requester r occupies bits [r*DATA_W +: DATA_W].
- req_tag  in  NUM_REQ*TAG_W  requester r occupies bits [r*TAG_W +: TAG_W].
- req_grant  out  NUM_REQ  combinational; result accepted this cycle.
- CDB_data_serialized  out  NUM_LANES*DATA_W  registered; lane 0 in the MSBs.
- CDB_tag_serialized  out  NUM_LANES*TAG_W  registered; lane 0 in the MSBs; an idle lane carries 8'h00.

Behaviour:
- Reset (asynchronous): CDB_data_serialized = 0, CDB_tag_serialized = 0, rr_ptr = 0. req_grant = 0 while reset is high.
- Handshake: a requester holds valid, data and tag stable until it sees grant. A transfer occurs when req_valid[r] and req_grant[r] are both high at a posedge. The requester may present a new result the next cycle.
- req_grant never asserts without req_valid. It is independent of req_data and req_tag.
- Selection: search indices rr_ptr, rr_ptr+1, … mod NUM_REQ. Grant the first NUM_LANES valid requesters found. The k-th granted requester goes to lane k.
- Pointer update: rr_ptr <= (last granted index + 1) mod NUM_REQ. If nothing is granted, rr_ptr is unchanged.
- Latency: a result granted in cycle t appears on its lane for exactly cycle t+1. The lane returns to zero at t+2 unless it is re-granted.
- Throughput: up to NUM_LANES results per cycle, with back-to-back grants to the same requester. If NUM_REQ <= NUM_LANES, every valid request is granted every cycle.
- Unused lanes carry data 0 and tag 0. tag_valid = 0 means consumers ignore the lane.
- A request whose tag has bit7 = 0 is still granted and broadcast verbatim; flagging it is the checker's responsibility.
- en low: req_grant = 0. The next posedge loads all lanes with zero; rr_ptr is held.
- Reset mid-operation: a result granted in the cycle reset asserts is discarded. This is acceptable because the whole machine flushes on reset.
- No combinational path from the CDB outputs back to req_grant.

Optional Feature:
- Macro: CDB_ARB_STATS_EN.
- With the macro defined, two output ports are added:
  - stat_broadcasts (32 bits): adds the number of grants each enabled cycle.
  - stat_stall_cycles (32 bits): increments on every enabled cycle in which some valid requester was not granted.
- Both counters saturate at all-ones and reset asynchronously to 0.
- Without the macro, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package cdb_pkg holds:
  - CDB_LANES = 4, TAG_W = 8, DATA_W = 32;
  - tag field constants: TAG_VALID_BIT = 7, unit one-hot codes MEM = 4'b1000, ADD = 4'b0100, MUL = 4'b0010, DIV = 4'b0001;
  - the tag_match function shared with the reservation stations.
- One combinational sub-module, cdb_rr_picker. It takes (req_valid, rr_ptr) and returns per-lane index plus valid, the grant vector and the next pointer. It is reusable by a future issue arbiter.

Test Plan:
- Async reset: with lanes non-zero, assert reset between clock edges → both CDB buses read 0 immediately and req_grant = 0; after release, the first grant search starts at index 0.
- Single requester: req 3 valid, data 32'h2A, tag 8'hAB → req_grant = 8'h08 the same cycle; next cycle lane0 = {tag AB, data 2A} and lanes 1-3 have tag 00; the cycle after, all lanes are zero.
- All 8 valid and held: cycle 1 grants 0,1,2,3 on lanes 0-3 and rr_ptr → 4; cycle 2 grants 4,5,6,7 and rr_ptr → 0; each CDB cycle carries four tags.
- Wrap-around: with rr_ptr = 6 and valid = {0,2,5,6,7} → grants 6,7,0,2 on lanes 0-3; 5 is not granted; rr_ptr → 3; next cycle grants 5 alone on lane 0.
- Enable gating: all 8 valid, en low for 3 cycles → req_grant = 0 and lanes are zero with rr_ptr held; when en rises, grants resume from the held pointer.
- Stats (CDB_ARB_STATS_EN): run the wrap-around scenario → stat_broadcasts = 5 and stat_stall_cycles = 1; preload stat_broadcasts near saturation → it clamps at 32'hFFFFFFFF.
